// File: rtl/ttl_sync_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : ttl_sync_counter_n
//  Description : WIDTH-bit synchronous modulo counter (161/163 successor) with
//                parallel load, up/down, enp/ent cascade and ripple carry out.
//                Optional macro TTL_CNT_AUTORELOAD_EN: terminal-count events
//                reload din instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module ttl_sync_counter_n #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] din,
    input  logic             n_load,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             max_min,
    output logic             rco
);

    localparam logic [WIDTH-1:0] c_TERM = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    // Power-up value matches the reset value so the first count is defined.
    logic [WIDTH-1:0] r_q = '0;

    logic             w_at_top;
    logic             w_at_zero;
    logic             w_count;
    logic [WIDTH-1:0] w_wrap_up;
    logic [WIDTH-1:0] w_wrap_dn;
    logic [WIDTH-1:0] w_up_next;
    logic [WIDTH-1:0] w_dn_next;

    assign w_at_top  = (r_q == c_TERM);
    assign w_at_zero = (r_q == c_ZERO);
    assign w_count   = enp & ent;

`ifdef TTL_CNT_AUTORELOAD_EN
    assign w_wrap_up = din;
    assign w_wrap_dn = din;
`else
    assign w_wrap_up = c_ZERO;
    assign w_wrap_dn = c_TERM;
`endif

    // Out-of-range values fall through to plain binary inc/dec until they re-enter range.
    assign w_up_next = w_at_top  ? w_wrap_up : r_q + 1'b1;
    assign w_dn_next = w_at_zero ? w_wrap_dn : r_q - 1'b1;

    always_ff @(posedge clk) begin
        if (res) begin
            r_q <= c_ZERO;
        end else if (!n_load) begin
            r_q <= din;
        end else if (w_count) begin
            r_q <= up ? w_up_next : w_dn_next;
        end
    end

    assign q       = r_q;
    assign max_min = up ? w_at_top : w_at_zero;
    assign rco     = max_min & ent;

endmodule
`default_nettype wire

// File: tb/tb_ttl_sync_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ttl_sync_counter_n
//  Description : Scoreboard bench for ttl_sync_counter_n (single MODULUS=10
//                counter plus a two-stage MODULUS=16 cascade).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ttl_sync_counter_n;

    typedef struct {
        int    q;
        bit    mm;
        bit    rco;
        int    clo;
        int    chi;
        bit    crco;
        string tag;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    logic       clk = 1'b0;
    logic       res = 1'b0, n_load = 1'b1, enp = 1'b0, ent = 1'b0, up = 1'b1;
    logic [3:0] din = 4'd0;
    logic [3:0] q;
    logic       max_min, rco;

    logic       c_res = 1'b0, c_nload = 1'b1, c_enp = 1'b0, c_ent = 1'b0, c_up = 1'b1;
    logic [3:0] c_dlo = 4'd0, c_dhi = 4'd0;
    logic [3:0] c_qlo, c_qhi;
    logic       c_mmlo, c_rcolo, c_mmhi, c_rcohi;

    // Cascade stimulus staged here, applied by cyc() at the falling edge.
    bit n_res = 0, n_nload = 1, n_enp = 0, n_ent = 0, n_up = 1;
    int n_dlo = 0, n_dhi = 0;

    int m_q = 0, m_lo = 0, m_hi = 0;

    always #5 clk = ~clk;

    ttl_sync_counter_n #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .res(res), .din(din), .n_load(n_load), .enp(enp), .ent(ent),
        .up(up), .q(q), .max_min(max_min), .rco(rco)
    );

    ttl_sync_counter_n #(.WIDTH(4), .MODULUS(16)) u_lo (
        .clk(clk), .res(c_res), .din(c_dlo), .n_load(c_nload), .enp(c_enp), .ent(c_ent),
        .up(c_up), .q(c_qlo), .max_min(c_mmlo), .rco(c_rcolo)
    );

    ttl_sync_counter_n #(.WIDTH(4), .MODULUS(16)) u_hi (
        .clk(clk), .res(c_res), .din(c_dhi), .n_load(c_nload), .enp(c_enp), .ent(c_rcolo),
        .up(c_up), .q(c_qhi), .max_min(c_mmhi), .rco(c_rcohi)
    );

    // One count step of a 4-bit modulo-m counter, straight from the counting rules.
    function automatic int step(input int cur, input int m, input int d, input bit u);
        bit auto_rl;
`ifdef TTL_CNT_AUTORELOAD_EN
        auto_rl = 1'b1;
`else
        auto_rl = 1'b0;
`endif
        if (u) begin
            if (cur == m - 1) return auto_rl ? d : 0;
            return (cur + 1) % 16;
        end
        if (cur == 0) return auto_rl ? d : m - 1;
        return cur - 1;
    endfunction

    function automatic bit term(input int cur, input int m, input bit u);
        return u ? (cur == m - 1) : (cur == 0);
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit nl, input int d, input bit ep,
                       input bit et, input bit u, input string tag);
        exp_t e;
        bit   lo_tc;
        @(negedge clk);
        res = r; n_load = nl; din = 4'(d); enp = ep; ent = et; up = u;
        c_res = n_res; c_nload = n_nload; c_enp = n_enp; c_ent = n_ent; c_up = n_up;
        c_dlo = 4'(n_dlo); c_dhi = 4'(n_dhi);

        if (r)               m_q = 0;
        else if (!nl)        m_q = d;
        else if (ep && et)   m_q = step(m_q, 10, d, u);

        lo_tc = term(m_lo, 16, n_up);
        if (n_res) begin
            m_lo = 0; m_hi = 0;
        end else if (!n_nload) begin
            m_lo = n_dlo; m_hi = n_dhi;
        end else if (n_enp && n_ent) begin
            if (lo_tc) m_hi = step(m_hi, 16, n_dhi, n_up);
            m_lo = step(m_lo, 16, n_dlo, n_up);
        end

        e.q    = m_q;
        e.mm   = term(m_q, 10, u);
        e.rco  = e.mm && et;
        e.clo  = m_lo;
        e.chi  = m_hi;
        e.crco = term(m_lo, 16, n_up) && term(m_hi, 16, n_up) && n_ent;
        e.tag  = tag;
        sbq.push_back(e);
    endtask

    // Monitor: the counter presents a new result after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk({e.tag, ".q"},        int'(q),       e.q);
                chk({e.tag, ".max_min"},  int'(max_min), int'(e.mm));
                chk({e.tag, ".rco"},      int'(rco),     int'(e.rco));
                chk({e.tag, ".casc_lo"},  int'(c_qlo),   e.clo);
                chk({e.tag, ".casc_hi"},  int'(c_qhi),   e.chi);
                chk({e.tag, ".casc_rco"}, int'(c_rcohi), int'(e.crco));
            end
        end
    end

    initial begin
        #1;
        chk("powerup.q", int'(q), 0);

        cyc(1, 1, 0, 1, 1, 1, "t1_reset");
        repeat (12) cyc(0, 1, 0, 1, 1, 1, "t1_up");

        cyc(0, 0, 4, 0, 0, 1, "t2_load4");
        cyc(0, 0, 7, 1, 1, 1, "t2_load_beats_count");
        cyc(0, 0, 4, 0, 0, 1, "t2_load4b");
        cyc(1, 0, 7, 1, 1, 1, "t2_reset_beats_load");

        cyc(0, 1, 0, 0, 1, 0, "t3_hold_down_at0");
        cyc(0, 1, 0, 1, 1, 0, "t3_down");
        cyc(0, 1, 0, 1, 1, 0, "t3_down");

        cyc(0, 0, 9, 0, 0, 1, "t4_load9");
        cyc(0, 1, 0, 1, 0, 1, "t4_ent0");
        cyc(0, 1, 0, 0, 1, 1, "t4_enp0");
        cyc(0, 1, 0, 0, 1, 0, "t4_dir_flip");

        cyc(0, 0, 13, 1, 1, 1, "t5_load13");
        repeat (12) cyc(0, 1, 0, 1, 1, 1, "t5_oor_up");
        cyc(0, 0, 12, 1, 1, 0, "t5_load12");
        repeat (4) cyc(0, 1, 0, 1, 1, 0, "t5_oor_down");

        cyc(0, 0, 9, 0, 0, 1, "t7_load9");
        cyc(0, 1, 3, 1, 1, 1, "t7_terminal");

        // Cascade: reset, 255 counts to FF, then rollover; main counter idles randomly.
        n_res = 1; n_nload = 1; n_enp = 1; n_ent = 1; n_up = 1; n_dlo = 0; n_dhi = 0;
        cyc(0, 1, 0, 0, 0, 1, "t6_reset");
        n_res = 0;
        for (int i = 0; i < 256; i++)
            cyc(0, 1, int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "t6_cascade");

        for (int i = 0; i < 600; i++) begin
            bit u_r;
            u_r = bit'($urandom_range(0, 1));
            n_res   = ($urandom_range(0, 63) == 0);
            n_nload = ($urandom_range(0, 15) != 0);
            n_enp   = ($urandom_range(0, 7) != 0);
            n_ent   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 31) == 0) n_up = ~n_up;
            n_dlo = int'($urandom_range(0, 15));
            n_dhi = int'($urandom_range(0, 15));
            cyc(($urandom_range(0, 47) == 0), ($urandom_range(0, 9) != 0),
                int'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 7) != 0), u_r, "rand");
        end

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (sbq.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
